scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 150 +++++++++++++++
 tb/tb_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Round-robin channel scanner driving a 2-to-4 decoder select/enable pair.
// Each enabled channel dwells for a fixed count, optionally followed by a blank gap.
module scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    output logic [1:0]         sel,
    output logic               enable,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK
    } state_t;

    state_t state, state_nx;

    logic [1:0]         sel_nx;
    logic               enable_nx;
    logic               busy_nx;
    logic               wrap_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
    logic [BLANK_W-1:0] blank_cnt, blank_cnt_nx;
    logic [BLANK_W-1:0] blank_cap, blank_cap_nx;
    logic [DWELL_W-1:0] dwell_load;
    logic [1:0]         low_ch;
    logic [1:0]         next_ch;
    logic [1:0]         idx;

    // Counters hold cycles remaining after the current one.
    assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

    always_comb begin
        low_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (chan_mask[i]) low_ch = 2'(i);
        end
    end

    // Circular search above sel; k=4 lands on sel itself.
    always_comb begin
        next_ch = sel;
        idx     = sel;
        for (int k = 4; k >= 1; k--) begin
            idx = sel + 2'(k);
            if (chan_mask[idx]) next_ch = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            blank_cap <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            enable    <= enable_nx;
            busy      <= busy_nx;
            wrap      <= wrap_nx;
            dwell_cnt <= dwell_cnt_nx;
            blank_cnt <= blank_cnt_nx;
            blank_cap <= blank_cap_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        enable_nx    = enable;
        busy_nx      = busy;
        wrap_nx      = 1'b0;
        dwell_cnt_nx = dwell_cnt;
        blank_cnt_nx = blank_cnt;
        blank_cap_nx = blank_cap;
        unique case (state)
            IDLE: begin
                enable_nx = 1'b0;
                busy_nx   = 1'b0;
                if (start && !stop && chan_mask != 4'd0) begin
                    state_nx     = ACTIVE;
                    sel_nx       = low_ch;
                    enable_nx    = 1'b1;
                    busy_nx      = 1'b1;
                    dwell_cnt_nx = dwell_load;
                    blank_cap_nx = blank;
                end
            end
            ACTIVE: begin
                if (stop || (dwell_cnt == '0 && chan_mask == 4'd0)) begin
                    state_nx     = IDLE;
                    enable_nx    = 1'b0;
                    busy_nx      = 1'b0;
                    dwell_cnt_nx = '0;
                    blank_cnt_nx = '0;
                end else if (dwell_cnt != '0) begin
                    dwell_cnt_nx = dwell_cnt - 1'b1;
                end else begin
                    sel_nx  = next_ch;
                    wrap_nx = (next_ch <= sel);
                    if (blank_cap == '0) begin
                        dwell_cnt_nx = dwell_load;
                        blank_cap_nx = blank;
                    end else begin
                        state_nx     = BLANK;
                        enable_nx    = 1'b0;
                        blank_cnt_nx = blank_cap - 1'b1;
                    end
                end
            end
            BLANK: begin
                if (stop) begin
                    state_nx     = IDLE;
                    enable_nx    = 1'b0;
                    busy_nx      = 1'b0;
                    dwell_cnt_nx = '0;
                    blank_cnt_nx = '0;
                end else if (blank_cnt != '0) begin
                    blank_cnt_nx = blank_cnt - 1'b1;
                end else begin
                    state_nx     = ACTIVE;
                    enable_nx    = 1'b1;
                    dwell_cnt_nx = dwell_load;
                    blank_cap_nx = blank;
                end
            end
            default: begin
                state_nx  = IDLE;
                enable_nx = 1'b0;
                busy_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural scan model.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] chan_mask;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic [1:0] sel;
    logic       enable;
    logic       busy;
    logic       wrap;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: elapsed-cycle count against a target length.
    bit       m_busy;
    bit       m_inblank;
    bit       m_en;
    bit       m_wrap;
    int       m_sel;
    int       m_el;
    int       m_len;
    int       m_blen;

    scan_sequencer #(.DWELL_W(8), .BLANK_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .blank     (blank),
        .sel       (sel),
        .enable    (enable),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d",
                      tag, $time, got, exp);
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_of(input int s, input logic [3:0] m);
        int j;
        for (int k = 1; k <= 4; k++) begin
            j = (s + k) % 4;
            if (m[j]) return j;
        end
        return s;
    endfunction

    function automatic int len_of(input logic [7:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_inblank = 0; m_en = 0; m_wrap = 0;
        m_sel = 0;  m_el = 0; m_len = 1; m_blen = 0;
    endtask

    task automatic model_step();
        int nx;
        m_wrap = 0;
        if (!m_busy) begin
            if (start && !stop && chan_mask != 0) begin
                m_busy = 1; m_inblank = 0; m_en = 1; m_el = 0;
                m_sel  = lowest(chan_mask);
                m_len  = len_of(dwell);
                m_blen = int'(blank);
            end
        end else if (stop) begin
            m_busy = 0; m_en = 0; m_inblank = 0;
        end else if (m_inblank) begin
            m_el++;
            if (m_el == m_blen) begin
                m_inblank = 0; m_en = 1; m_el = 0;
                m_len  = len_of(dwell);
                m_blen = int'(blank);
            end
        end else begin
            m_el++;
            if (m_el == m_len) begin
                if (chan_mask == 0) begin
                    m_busy = 0; m_en = 0;
                end else begin
                    nx     = next_of(m_sel, chan_mask);
                    m_wrap = (nx <= m_sel);
                    m_sel  = nx;
                    m_el   = 0;
                    if (m_blen == 0) begin
                        m_len  = len_of(dwell);
                        m_blen = int'(blank);
                    end else begin
                        m_inblank = 1; m_en = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("sel",    32'(sel),    32'(m_sel));
        check("enable", 32'(enable), 32'(m_en));
        check("busy",   32'(busy),   32'(m_busy));
        check("wrap",   32'(wrap),   32'(m_wrap));
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_sel",    32'(sel),    32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_wrap",   32'(wrap),   32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        chan_mask = 4'd0; dwell = 8'd0; blank = 4'd0;
        model_reset();
        #12;
        check("init_sel",    32'(sel),    32'd0);
        check("init_enable", 32'(enable), 32'd0);
        check("init_busy",   32'(busy),   32'd0);
        check("init_wrap",   32'(wrap),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // all four channels, back-to-back dwell
        chan_mask = 4'b1111; dwell = 8'd3; blank = 4'd0;
        start = 1'b1;
        run(14);
        stop = 1'b1;
        run(2);

        // alternating channels with gaps
        chan_mask = 4'b1010; dwell = 8'd2; blank = 4'd2;
        start = 1'b1;
        run(14);
        stop = 1'b1;
        run(2);

        // single channel, zero dwell
        chan_mask = 4'b0100; dwell = 8'd0; blank = 4'd0;
        start = 1'b1;
        run(6);
        check("s3_sel", 32'(sel), 32'd2);
        check("s3_wrap", 32'(wrap), 32'd1);
        stop = 1'b1;
        run(1);

        // stop on second dwell cycle, then restart
        chan_mask = 4'b0110; dwell = 8'd5; blank = 4'd1;
        start = 1'b1;
        run(1);
        stop = 1'b1;
        run(1);
        check("s4_enable", 32'(enable), 32'd0);
        check("s4_busy",   32'(busy),   32'd0);
        run(2);
        start = 1'b1;
        run(1);
        check("s4_restart", 32'(sel), 32'd1);
        stop = 1'b1;
        run(1);

        // reset mid-blank, then start with empty mask
        chan_mask = 4'b1010; dwell = 8'd2; blank = 4'd3;
        start = 1'b1;
        run(3);
        check("s5_blank", 32'(enable), 32'd0);
        async_reset();
        chan_mask = 4'd0; start = 1'b1;
        run(3);
        check("s5_idle", 32'(busy), 32'd0);

        // start+stop together, then mask vanishes mid-dwell
        chan_mask = 4'b0011; dwell = 8'd4; blank = 4'd0;
        start = 1'b1; stop = 1'b1;
        run(2);
        start = 1'b1;
        run(2);
        chan_mask = 4'd0;
        run(4);
        check("s6_idle", 32'(busy), 32'd0);

        // longest dwell and blank
        chan_mask = 4'b1001; dwell = 8'd255; blank = 4'd15;
        start = 1'b1;
        run(600);
        stop = 1'b1;
        run(1);

        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(7) == 0);
            stop  = ($urandom_range(40) == 0);
            if ($urandom_range(15) == 0)
                chan_mask = 4'($urandom_range(15));
            if ($urandom_range(20) == 0)
                dwell = 8'($urandom_range(255));
            else
                dwell = 8'($urandom_range(4));
            if ($urandom_range(30) == 0)
                blank = 4'd15;
            else
                blank = 4'($urandom_range(3));
            if ($urandom_range(400) == 0) async_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
